rns_coeff_streamer: RTL and testbench

Downstream consumer of the RNS reduction stage's message BRAM. Once the RNS stage has written a full polynomial of residues mod q, this block reads every coefficient sequentially. It emits each one on a 64-bit AXI-Stream master toward the host DMA, with full backpressure support. A small prefetch FIFO hides the BRAM read latency so the block sustains one coefficient per cycle.

---
 rtl/rns_coeff_streamer.sv | 177 +++++++++++++++++
 tb/tb_rns_coeff_streamer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rns_coeff_streamer.sv
// rns_coeff_streamer: reads one polynomial of RNS residues out of the message
// BRAM in address order and streams it to the host DMA over AXI-Stream.
// A credit-checked prefetch FIFO covers the BRAM read latency, so the block
// keeps up one coefficient per cycle while tready stays high.
module rns_coeff_streamer #(
    parameter int LOGN        = 15,
    parameter int LOGQ        = 54,
    parameter int BRAM_RD_LAT = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      current_n,
    output logic [LOGN-1:0] bram_rd_addr,
    output logic            bram_rd_en,
    input  logic [LOGQ-1:0] bram_rd_data,
    output logic [63:0]     m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            m_axis_tlast,
    output logic            busy,
    output logic            done
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int IFW = $clog2(BRAM_RD_LAT + 1);
    localparam int OW  = CW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LOGN-1:0]        last_idx;
    logic [LOGN-1:0]        rd_ptr;
    logic [LOGN-1:0]        last_addr;
    logic [LOGN-1:0]        beat_cnt;
    logic [BRAM_RD_LAT-1:0] vld_pipe;
    logic [LOGQ-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_idx;
    logic [PW-1:0]          rd_idx;
    logic [CW-1:0]          fifo_count;
    logic [IFW-1:0]         in_flight;
    logic [OW-1:0]          occupancy;
    logic [1:0]             n_eff;
    logic                   credit_ok;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   fire_last;
    logic                   accept_start;

    // Size select 3 aliases to the largest polynomial.
    assign n_eff        = (current_n == 2'd3) ? 2'd2 : current_n;
    assign accept_start = (state == IDLE) && start;

    // Reads still travelling through the BRAM pipeline.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < BRAM_RD_LAT; i++) begin
            in_flight = in_flight + IFW'(vld_pipe[i]);
        end
    end

    // Every outstanding read already owns a FIFO slot, so a push can never
    // find the FIFO full. A pop in the same cycle is not counted as credit;
    // steady-state occupancy stays low enough to issue every cycle anyway.
    assign occupancy = OW'(in_flight) + OW'(fifo_count);
    assign credit_ok = occupancy < OW'(FIFO_DEPTH);

    assign push      = vld_pipe[BRAM_RD_LAT-1];
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign fire_last = pop && m_axis_tlast;

    // Next-state and read-issue decode.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (rd_ptr == last_idx) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (fire_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Read pointer, polynomial length and last issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            last_idx  <= '0;
            last_addr <= '0;
        end else if (accept_start) begin
            rd_ptr   <= '0;
            last_idx <= LOGN'((32'd1 << (32'd13 + 32'(n_eff))) - 32'd1);
        end else if (issue) begin
            rd_ptr    <= rd_ptr + LOGN'(1);
            last_addr <= rd_ptr;
        end
    end

    // Valid shift register mirroring the BRAM read pipeline; clearing it on
    // reset drops any data still in flight from an aborted stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx] <= bram_rd_data;
    end

    // FIFO pointers and occupancy; push and pop together leave the count as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_idx <= wr_idx + PW'(1);
            if (pop)  rd_idx <= rd_idx + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output beat counter used to place tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            beat_cnt <= '0;
        else if (accept_start) beat_cnt <= '0;
        else if (pop)          beat_cnt <= beat_cnt + LOGN'(1);
    end

    // Completion pulse in the cycle after the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= fire_last;
    end

    assign bram_rd_en    = issue;
    assign bram_rd_addr  = issue ? rd_ptr : last_addr;
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == last_idx);
    assign m_axis_tdata  = m_axis_tvalid ? {{(64-LOGQ){1'b0}}, fifo_mem[rd_idx]} : 64'd0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_rns_coeff_streamer.sv
// Directed bench for rns_coeff_streamer: a behavioural 2-cycle BRAM returns
// coeff(addr) = addr * 0x1_0000_0001 mod 2^54, and each stream is checked
// beat by beat against that formula.
module tb_rns_coeff_streamer;

    localparam int LOGN = 15;
    localparam int LOGQ = 54;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      current_n = 2'd0;
    logic [LOGN-1:0] bram_rd_addr;
    logic            bram_rd_en;
    logic [LOGQ-1:0] bram_rd_data;
    logic [63:0]     m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic            m_axis_tlast;
    logic            busy;
    logic            done;

    int vectors = 0;
    int miscompares = 0;

    // run_stream results
    int beats, data_err, last_err, stab_err, ovf_err, busy_err;
    int done_cnt, done_iter, last_fire_iter, first_vld_iter, timed_out;

    always #5 clk = ~clk;

    rns_coeff_streamer #(.LOGN(LOGN), .LOGQ(LOGQ), .BRAM_RD_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .current_n(current_n),
        .bram_rd_addr(bram_rd_addr), .bram_rd_en(bram_rd_en), .bram_rd_data(bram_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    function automatic logic [63:0] coeff(input int i);
        logic [63:0] v;
        v = 64'(i) * 64'h0000_0001_0000_0001;
        return v & 64'h003F_FFFF_FFFF_FFFF;
    endfunction

    // Message BRAM model: address registered on issue, data one stage later.
    logic [LOGQ-1:0] st1 = '0;
    logic [LOGQ-1:0] st2 = '0;
    always @(posedge clk) begin
        if (bram_rd_en) st1 <= LOGQ'(coeff(int'(bram_rd_addr)));
        st2 <= st1;
    end
    assign bram_rd_data = st2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] n);
        @(negedge clk);
        current_n = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: tready always high; mode 1: tready dropped on ~30% of cycles.
    // restart_at >= 0 pulses start when that many beats are done.
    // abort_at >= 0 drops rst_n between edges once that many beats are done.
    task automatic run_stream(input string tag, input int n_beats, input int mode,
                              input int restart_at, input int abort_at);
        int iter = 0;
        int post = 0;
        bit stall = 0;
        bit restarted = 0;
        bit aborted = 0;
        logic [63:0] hd = '0;
        logic hl = 1'b0;
        beats = 0; data_err = 0; last_err = 0; stab_err = 0; ovf_err = 0; busy_err = 0;
        done_cnt = 0; done_iter = -1; last_fire_iter = -10; first_vld_iter = -1; timed_out = 0;
        while (1) begin
            @(negedge clk);
            m_axis_tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) >= 3);
            start = 1'b0;
            if (restart_at >= 0 && beats == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
            #1;
            if (m_axis_tvalid && first_vld_iter < 0) first_vld_iter = iter;
            if (stall && (!m_axis_tvalid || m_axis_tdata !== hd || m_axis_tlast !== hl)) stab_err++;
            if (dut.fifo_count > 4) ovf_err++;
            if (done) begin
                done_cnt++;
                done_iter = iter;
                if (busy) busy_err++;
            end
            if (!m_axis_tvalid && m_axis_tlast) last_err++;
            if (m_axis_tvalid && (m_axis_tlast !== (beats == n_beats - 1))) last_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (m_axis_tdata !== coeff(beats)) data_err++;
                if (beats == n_beats - 1) last_fire_iter = iter;
                beats++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            hd = m_axis_tdata;
            hl = m_axis_tlast;
            if (abort_at >= 0 && beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst_ctl"},
                    {44'd0, bram_rd_en, bram_rd_addr, m_axis_tvalid, m_axis_tlast, busy, done}, 64'd0);
                chk({tag, "_rst_tdata"}, m_axis_tdata, 64'd0);
                aborted = 1;
                break;
            end
            if (beats >= n_beats) post++;
            if (post > 3) break;
            iter++;
            if (iter > n_beats * 3 + 200) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
            chk({tag, "_beats"}, 64'(beats), 64'(n_beats));
            chk({tag, "_data_err"}, 64'(data_err), 64'd0);
            chk({tag, "_tlast_err"}, 64'(last_err), 64'd0);
            chk({tag, "_hold_err"}, 64'(stab_err), 64'd0);
            chk({tag, "_fifo_ovf"}, 64'(ovf_err), 64'd0);
            chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
            chk({tag, "_done_lat"}, 64'(done_iter - last_fire_iter), 64'd1);
            chk({tag, "_busy_at_done"}, 64'(busy_err), 64'd0);
            chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int issued;
        int addr_err;
        int hold_err;
        int stale;

        // Reset state
        #3;
        chk("reset_ctl", {44'd0, bram_rd_en, bram_rd_addr, m_axis_tvalid, m_axis_tlast, busy, done}, 64'd0);
        chk("reset_tdata", m_axis_tdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 2^13 stream with latency checks
        m_axis_tready = 1'b1;
        do_start(2'd0);
        #1;
        chk("lat_rd_en_n0", 64'(bram_rd_en), 64'd1);
        chk("lat_rd_addr_n0", 64'(bram_rd_addr), 64'd0);
        chk("lat_busy_n0", 64'(busy), 64'd1);
        chk("lat_tvalid_n0", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk); #1;
        chk("lat_tvalid_n1", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk); #1;
        chk("lat_tvalid_n2", 64'(m_axis_tvalid), 64'd0);
        run_stream("basic", 8192, 0, -1, -1);
        chk("basic_first_valid_n3", 64'(first_vld_iter), 64'd0);

        // Size select
        do_start(2'd1);
        run_stream("n1", 16384, 0, -1, -1);
        do_start(2'd3);
        run_stream("n3", 32768, 0, -1, -1);

        // Backpressure stall, then a start pulse mid-stream that must be ignored
        m_axis_tready = 1'b0;
        do_start(2'd0);
        issued = 0; addr_err = 0; hold_err = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bram_rd_en) begin
                if (bram_rd_addr !== LOGN'(issued)) addr_err++;
                issued++;
            end
            if (i >= 3 && (!m_axis_tvalid || m_axis_tdata !== coeff(0))) hold_err++;
            @(negedge clk);
        end
        #1;
        chk("stall_reads", 64'(issued), 64'd4);
        chk("stall_addr_err", 64'(addr_err), 64'd0);
        chk("stall_hold_err", 64'(hold_err), 64'd0);
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_tdata", m_axis_tdata, coeff(0));
        run_stream("stall_restart", 8192, 0, 100, -1);

        // Asynchronous reset mid-stream
        do_start(2'd0);
        run_stream("abort", 8192, 0, -1, 500);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (m_axis_tvalid || busy || bram_rd_en || done) stale++;
        end
        chk("post_reset_idle", 64'(stale), 64'd0);

        // Fresh stream after reset under random backpressure
        do_start(2'd0);
        run_stream("random", 8192, 1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
